counter: RTL and testbench



---
 rtl/counter.sv | 160 ++++++++++++++++
 tb/tb_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//
// Triggered one-shot up-counter used as a step sequencer. A rising edge on
// `trigger` starts a run that drives `out` through 1, 2, ..., MAX_COUNT on
// consecutive clock cycles. After the terminal count `out` returns to 0 and
// the block waits for the next rising edge. A rising edge seen during a run
// restarts the run at 1.
//
// Parameters:
//   WIDTH      - width of `out` (1..31)
//   MAX_COUNT  - terminal count, 1 <= MAX_COUNT <= 2**WIDTH - 1
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst_n      - asynchronous reset, ACTIVE-HIGH despite the name; clears
//                state, edge-detect history and count immediately
//   trigger    - level start request, only its synchronous rising edge acts
//   out        - registered current step number (0 when idle)
// ---------------------------------------------------------------------------
module counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trigger,
   output logic [WIDTH-1:0] out
);

   // Parameter legality is checked at elaboration so an out-of-range
   // terminal count can never be built.
   if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
      $error("counter: WIDTH must be in 1..31");
   end
   if (MAX_COUNT < 1 || longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_max
      $error("counter: MAX_COUNT must be in 1..2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX_COUNT);

   // Two-hot-free encoding: 2'b00 and 2'b11 are illegal and recover to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b01,
      ST_COUNT = 2'b10
   } state_t;

   state_t           state_r;
   logic             trig_d_r;
   logic [WIDTH-1:0] count_r;

   logic             start_s;
   logic             at_max_s;

   // Next step value, wraps modulo 2**WIDTH (wrap is unreachable because
   // the run ends at CNT_MAX).
   function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur);
      next_count = cur + CNT_ONE;
   endfunction

   // Rising-edge detect of the level trigger against the last sampled value.
   assign start_s  = trigger & ~trig_d_r;

   // Terminal-count detect on the current count.
   assign at_max_s = (count_r == CNT_MAX);

   // Sequencer FSM: edge history, state and count register in one block.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_r  <= ST_IDLE;
         trig_d_r <= 1'b0;
         count_r  <= CNT_ZERO;
      end else begin
         trig_d_r <= trigger;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r <= ST_COUNT;
                  count_r <= CNT_ONE;
               end else begin
                  state_r <= ST_IDLE;
                  count_r <= CNT_ZERO;
               end
            end
            ST_COUNT: begin
               // A retrigger wins over the terminal count, so a start on the
               // last step continues straight into a new run with no idle gap.
               if (start_s) begin
                  state_r <= ST_COUNT;
                  count_r <= CNT_ONE;
               end else if (at_max_s) begin
                  state_r <= ST_IDLE;
                  count_r <= CNT_ZERO;
               end else begin
                  state_r <= ST_COUNT;
                  count_r <= next_count(count_r);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               count_r <= CNT_ZERO;
            end
         endcase
      end
   end

   assign out = count_r;

   counter_chk #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT)
   ) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .state (state_r),
      .count (count_r)
   );

endmodule

// ---------------------------------------------------------------------------
// counter_chk
//
// Run-time invariants of the counter FSM. Contains only immediate assertions
// and no logic that affects the design.
//
// Ports:
//   clk    - design clock
//   rst_n  - active-high asynchronous reset of the design
//   state  - raw state register encoding
//   count  - count register
// ---------------------------------------------------------------------------
module counter_chk #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 15
) (
   input logic             clk,
   input logic             rst_n,
   input logic [1:0]       state,
   input logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX_COUNT);

   // Sample invariants on every clock edge outside reset.
   always @(posedge clk) begin
      if (rst_n == 1'b0) begin
         assert (state == 2'b01 || state == 2'b10)
            else $error("counter_chk: illegal state encoding %b", state);
         assert (count <= CNT_MAX)
            else $error("counter_chk: count %0d above terminal count", count);
         assert (state != 2'b01 || count == CNT_ZERO)
            else $error("counter_chk: nonzero count %0d while idle", count);
      end
   end

endmodule

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter
//
// Directed self-checking bench for counter. Three instances share clock and
// reset: the default (MAX_COUNT = 15), MAX_COUNT = 5 and MAX_COUNT = 1.
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, so every check sees the value settled after the edge.
// ---------------------------------------------------------------------------
module tb_counter;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       trig  = 1'b0;
   logic       trig5 = 1'b0;
   logic       trig1 = 1'b0;
   logic [3:0] out;
   logic [3:0] out5;
   logic [3:0] out1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   counter #(.WIDTH(4), .MAX_COUNT(15)) dut (
      .clk     (clk),
      .rst_n   (rst),
      .trigger (trig),
      .out     (out)
   );

   counter #(.WIDTH(4), .MAX_COUNT(5)) dut5 (
      .clk     (clk),
      .rst_n   (rst),
      .trigger (trig5),
      .out     (out5)
   );

   counter #(.WIDTH(4), .MAX_COUNT(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst),
      .trigger (trig1),
      .out     (out1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   initial begin
      // 1. Reset asserted between edges: out clears without a clock edge.
      #2 rst = 1'b1;
      #1;
      chk("reset_async", out, 4'd0);
      chk("reset_async5", out5, 4'd0);
      chk("reset_async1", out1, 4'd0);
      step();
      chk("reset_held", out, 4'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("idle_%0d", i), out, 4'd0);
      end

      // 2. Single one-edge pulse: 1..15 then 0, stays 0.
      trig = 1'b1;
      step();
      trig = 1'b0;
      chk("pulse_1", out, 4'd1);
      for (int k = 2; k <= 15; k++) begin
         step();
         chk($sformatf("pulse_%0d", k), out, 4'(k));
      end
      step();
      chk("pulse_end", out, 4'd0);
      step();
      chk("pulse_stay0", out, 4'd0);

      // 3. Retrigger at step 6.
      trig = 1'b1;
      step();
      trig = 1'b0;
      chk("retrig_first", out, 4'd1);
      for (int k = 2; k <= 6; k++) begin
         step();
      end
      chk("retrig_pre6", out, 4'd6);
      trig = 1'b1;
      step();
      trig = 1'b0;
      chk("retrig_restart", out, 4'd1);
      for (int k = 2; k <= 15; k++) begin
         step();
         chk($sformatf("retrig_%0d", k), out, 4'(k));
      end
      step();
      chk("retrig_end", out, 4'd0);

      // 4. Trigger held for 30 edges: exactly one run.
      trig = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         step();
         chk($sformatf("held_%0d", i), out, (i <= 15) ? 4'(i) : 4'd0);
      end
      trig = 1'b0;
      step();
      chk("held_drop", out, 4'd0);
      trig = 1'b1;
      step();
      trig = 1'b0;
      chk("held_rearm", out, 4'd1);
      for (int k = 2; k <= 15; k++) begin
         step();
      end
      step();
      chk("held_rearm_end", out, 4'd0);

      // 5. Rising edge sampled on the terminal-count edge.
      trig = 1'b1;
      step();
      trig = 1'b0;
      for (int k = 2; k <= 15; k++) begin
         step();
      end
      chk("coll_at15", out, 4'd15);
      trig = 1'b1;
      step();
      trig = 1'b0;
      chk("coll_1", out, 4'd1);
      step();
      chk("coll_2", out, 4'd2);
      step();
      chk("coll_3", out, 4'd3);
      for (int k = 4; k <= 15; k++) begin
         step();
      end
      step();
      chk("coll_end", out, 4'd0);

      // 6a. Reset mid-run at 9, with trigger high when reset releases.
      trig = 1'b1;
      step();
      trig = 1'b0;
      for (int k = 2; k <= 9; k++) begin
         step();
      end
      chk("midrst_at9", out, 4'd9);
      #3 rst = 1'b1;
      #1;
      chk("midrst_async", out, 4'd0);
      trig = 1'b1;
      step();
      chk("midrst_held", out, 4'd0);
      rst = 1'b0;
      step();
      trig = 1'b0;
      chk("midrst_restart_1", out, 4'd1);
      step();
      chk("midrst_restart_2", out, 4'd2);
      step();
      chk("midrst_restart_3", out, 4'd3);
      for (int k = 4; k <= 15; k++) begin
         step();
      end
      step();
      chk("midrst_end", out, 4'd0);

      // 6b. MAX_COUNT = 5: 1,2,3,4,5,0.
      chk("max5_idle", out5, 4'd0);
      trig5 = 1'b1;
      step();
      trig5 = 1'b0;
      chk("max5_1", out5, 4'd1);
      for (int k = 2; k <= 5; k++) begin
         step();
         chk($sformatf("max5_%0d", k), out5, 4'(k));
      end
      step();
      chk("max5_end", out5, 4'd0);

      // 6c. MAX_COUNT = 1: one cycle of 1, then 0.
      chk("max1_idle", out1, 4'd0);
      trig1 = 1'b1;
      step();
      trig1 = 1'b0;
      chk("max1_1", out1, 4'd1);
      step();
      chk("max1_end", out1, 4'd0);
      step();
      chk("max1_stay0", out1, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
